// File: rtl/datapath_pkg.sv
// Shared datapath types and constants for the serial arithmetic blocks.
package datapath_pkg;

    localparam int unsigned SLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : datapath_pkg

// File: rtl/sub16_serial_sub4.sv
// Combinational SLICE-bit subtract slice: {bout, d} = a - b - bin.
module sub4
    import datapath_pkg::*;
#(
    parameter int unsigned W = SLICE_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] ext_diff;

    // Zero-extended difference; the extra MSB is the borrow-out.
    assign ext_diff = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    assign d        = ext_diff[W-1:0];
    assign bout     = ext_diff[W];

endmodule : sub4

// File: rtl/sub16_serial.sv
// Multi-cycle unsigned subtractor: one SLICE-bit slice per clock, LSB first,
// with valid/ready handshakes on operands and result.
module sub16_serial
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE) != 0) begin : g_bad_width
        $error("sub16_serial: WIDTH must be an integer multiple of SLICE");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               brw_q, brw_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SLICE-1:0]   a_sl [NSLICE];
    logic [SLICE-1:0]   b_sl [NSLICE];
    logic [SLICE-1:0]   slice_diff;
    logic               slice_brw;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slices
        assign a_sl[k] = a_q[k*SLICE +: SLICE];
        assign b_sl[k] = b_q[k*SLICE +: SLICE];
    end

    // Single slice time-multiplexed over the operand by the slice counter.
    sub4 #(
        .W (SLICE)
    ) u_slice (
        .a    (a_sl[cnt_q]),
        .b    (b_sl[cnt_q]),
        .bin  (brw_q),
        .d    (slice_diff),
        .bout (slice_brw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < NSLICE; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        d_d[k*SLICE +: SLICE] = slice_diff;
                    end
                end
                brw_d = slice_brw;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    bout_d  = slice_brw;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bout      = bout_q;

endmodule : sub16_serial

// File: tb/tb_sub16_serial.sv
// Directed and scoreboarded bench for sub16_serial (WIDTH=16, SLICE=4).
module tb_sub16_serial;

    localparam int unsigned NSLICE = 4;
    localparam int unsigned NRAND  = 1000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;

    int n_checks;
    int n_fail;

    sub16_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure latency and check the result; leaves DUT in DONE.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          input logic [15:0] ed, input logic eb, input string tag);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NSLICE));
        check({tag, "_d"}, 32'(d), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [16:0] exp_q[$];
    logic [16:0] exp_v;
    logic        fire_in, fire_out;
    int          sent, recvd, cycles;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        tick();
        tick();
        check("reset_state", {14'd0, in_ready, out_valid, d}, {14'd0, 1'b1, 1'b0, 16'h0000});
        check("reset_bout", {31'd0, bout}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", {31'd0, in_ready}, 32'd1);

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, "basic");
        release_result("basic");
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, "wrap");
        release_result("wrap");
        run_op(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, "msb_bin");
        release_result("msb_bin");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "eq_bin");
        release_result("eq_bin");
        run_op(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, "eq_zero");
        release_result("eq_zero");

        // Backpressure: result must hold while new operands are offered and ignored.
        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            a = 16'h5555 + 16'(i); b = 16'h0101; bin = 1'b1; in_valid = 1'b1;
            tick();
            check("bp_hold", {14'd0, in_ready, out_valid, d}, {14'd0, 1'b0, 1'b1, 16'h1000});
            check("bp_hold_bout", {31'd0, bout}, 32'd0);
        end
        in_valid = 1'b0;
        release_result("bp");
        run_op(16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, "bp_next");
        release_result("bp_next");

        // Reset in the middle of RUN (cnt == 2).
        a = 16'h9999; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_run_state", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {14'd0, in_ready, out_valid, d}, {14'd0, 1'b1, 1'b0, 16'h0000});
        check("midrst_bout", {31'd0, bout}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, "after_rst");
        release_result("after_rst");

        // Random back-to-back traffic against a scoreboard.
        sent = 0; recvd = 0; cycles = 0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = 1'b1;
        out_ready = 1'($urandom);
        while (recvd < NRAND && cycles < 20000) begin
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_in) begin
                exp_q.push_back({1'b0, a} - {1'b0, b} - 17'(bin));
                sent++;
            end
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_result", {15'd0, bout, d}, {15'd0, exp_v});
                end
                recvd++;
            end
            tick();
            cycles++;
            if (fire_in) begin
                if (sent < NRAND && ($urandom_range(0, 7) != 0)) begin
                    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end else if (!in_valid && sent < NRAND) begin
                a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_count", 32'(recvd), 32'(NRAND));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sub16_serial

// File: doc/sub16_serial.md
Name: sub16_serial

Overview:
- Multi-cycle unsigned subtractor: computes D = A - B - BIN on WIDTH-bit operands, one SLICE-bit nibble per clock, LSB slice first.
- Borrow is carried between slices in a register.
- Complements the existing combinational ripple adders in the datapath library.
- Trades latency for area and uses valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE (elaboration error otherwise).
- SLICE, 4, bits processed per cycle.
- NSLICE, WIDTH/SLICE, derived local constant; number of compute cycles.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; in_ready=1, out_valid=0, d=0, bout=0.
  - Operand, borrow and slice-counter registers cleared.
- Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b and bin; clear cnt; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, slice k=cnt: {brw_next, diff} = a[k] - b[k] - brw, using the zero-extended (SLICE+1)-bit difference.
  - diff is written to d[k*SLICE +: SLICE]; brw<=brw_next; cnt<=cnt+1.
  - When cnt==NSLICE-1: go to DONE and load bout with brw_next.
- DONE:
  - out_valid=1; d and bout held stable until out_valid&out_ready.
  - On that handshake, go to IDLE.
  - out_ready may be held high early; the handshake then completes in the first DONE cycle.
- Latency: operands accepted at edge E; out_valid high after edge E+NSLICE (4 for defaults).
- Minimum initiation interval is NSLICE+2 cycles: accept, NSLICE computes, DONE, then IDLE.
- in_valid outside IDLE is ignored; the producer must hold its operands until in_ready is sampled high.
- d bits not yet computed during RUN are don't-care but must not be presented with out_valid=1.
- Result is registered; no combinational path from a/b/bin to d/bout, or from out_ready to in_ready.
- Wrap-around: results are modulo 2^WIDTH (0x0000-0x0001 = 0xFFFF, bout=1).
- a==b with bin=0 gives d=0, bout=0.
- Counter width is clog2(NSLICE), minimum 1 bit.
- When NSLICE==1, RUN lasts exactly one cycle.

Decomposition:
- Shared package (datapath_pkg):
  - State enum typedef: IDLE/RUN/DONE, 2 bits.
  - Default SLICE constant.
- Sub-module sub4: combinational SLICE-bit slice, ports a, b, bin, d, bout, implementing {bout,d} = a - b - bin with bout from the extended MSB.
  - Instantiated once and time-multiplexed over slices through a mux on cnt.

Test Plan:
- a=0x1234, b=0x0234, bin=0 -> d=0x1000, bout=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1; the borrow ripples through all 4 slices.
- a=0x8000, b=0x0000, bin=1 -> d=0x7FFF, bout=0. Also a=0xFFFF, b=0xFFFF, bin=1 -> d=0xFFFF, bout=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> d/bout/out_valid stable; in_ready stays 0; new in_valid with other operands ignored.
  - Release out_ready -> IDLE next cycle, then the next accept occurs.
- Assert rst_n low for 1 cycle while cnt==2 in RUN -> immediately out_valid=0, d=0, bout=0, in_ready=1. The subsequent operation 0x0005-0x0003 gives d=0x0002.
- 1000 random back-to-back operations with random out_ready stalls -> each result matches the scoreboard {bout,d} = {1'b0,a} - b - bin, in order, no drops or duplicates.
